// File: rtl/ram_4x4_sp.sv
// ram_4x4_sp
// Single-port synchronous RAM with a registered read port and a per-bit write
// mask that is fixed when the RAM is elaborated. Every enabled clock edge does
// exactly one access, either a read or a read-first write.
//
// Parameters:
//   AW   - address width; the RAM holds 2^AW words
//   DW   - data word width
//   MASK - write mask; a 1 bit is writable, a 0 bit always keeps its reset value
//
// Ports:
//   CLK  - clock; all state changes on its rising edge
//   RSTN - synchronous active-low clear of every word and of Q
//   A    - word address, shared by reads and writes
//   D    - write data
//   EN   - access enable; when low, memory and Q hold
//   WR   - 1 = write, 0 = read (only used when EN is high)
//   Q    - registered read data
module ram_4x4_sp #(
  parameter int              AW   = 4,
  parameter int              DW   = 4,
  parameter logic [DW-1:0]   MASK = {DW{1'b1}}
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  input  logic          EN,
  input  logic          WR,
  output logic [DW-1:0] Q
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] storedWord;
  logic [DW-1:0] mergedWord;

  // The word currently held at the addressed location, and the value it
  // would take on a write: masked-off bits come from the old word, writable
  // bits come from D.
  assign storedWord = mem[A];
  assign mergedWord = (storedWord & ~MASK) | (D & MASK);

  // Storage and the output register share one clocked process. Reset wins
  // over any access on the same edge, so a write coinciding with reset is
  // dropped. Q always captures the word as it was before this edge, which
  // gives read-first behaviour on a write with no bypass path.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      Q <= '0;
    end else if (EN) begin
      Q <= storedWord;
      if (WR) begin
        mem[A] <= mergedWord;
      end
    end
  end

endmodule

// File: tb/tb_ram_4x4_sp.sv
// tb_ram_4x4_sp
// Self-checking bench for ram_4x4_sp. Three instances share one stimulus
// stream and differ only in MASK (F, 7 and 0). A behavioural model built from
// plain arrays predicts memory contents and Q for each instance.
module tb_ram_4x4_sp;

  logic       clk;
  logic       rstN;
  logic [3:0] addr;
  logic [3:0] wrData;
  logic       en;
  logic       wr;
  logic [3:0] qFull;
  logic [3:0] qLow;
  logic [3:0] qZero;

  int total = 0;
  int bad   = 0;

  // Reference model: one array and one Q value per instance.
  logic [3:0] refMemFull [16];
  logic [3:0] refMemLow  [16];
  logic [3:0] refMemZero [16];
  logic [3:0] refQFull;
  logic [3:0] refQLow;
  logic [3:0] refQZero;

  ram_4x4_sp #(.AW(4), .DW(4), .MASK(4'hF)) dutFull (
    .CLK(clk), .RSTN(rstN), .A(addr), .D(wrData), .EN(en), .WR(wr), .Q(qFull)
  );

  ram_4x4_sp #(.AW(4), .DW(4), .MASK(4'h7)) dutLow (
    .CLK(clk), .RSTN(rstN), .A(addr), .D(wrData), .EN(en), .WR(wr), .Q(qLow)
  );

  ram_4x4_sp #(.AW(4), .DW(4), .MASK(4'h0)) dutZero (
    .CLK(clk), .RSTN(rstN), .A(addr), .D(wrData), .EN(en), .WR(wr), .Q(qZero)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Applies one access rule to a model array using the instance's mask.
  task automatic modelAccess(inout logic [3:0] mem [16], inout logic [3:0] q,
                             input logic [3:0] mask, input logic r,
                             input logic e, input logic w,
                             input logic [3:0] a, input logic [3:0] d);
    if (!r) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      q = 4'h0;
    end else if (e) begin
      q = mem[a];
      if (w) mem[a] = (mem[a] & ~mask) | (d & mask);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, advances the model at
  // the rising edge and checks all three outputs shortly afterwards.
  task automatic applyStimulus(input string tag, input logic r, input logic e,
                               input logic w, input logic [3:0] a,
                               input logic [3:0] d);
    @(negedge clk);
    rstN   = r;
    en     = e;
    wr     = w;
    addr   = a;
    wrData = d;
    @(posedge clk);
    modelAccess(refMemFull, refQFull, 4'hF, r, e, w, a, d);
    modelAccess(refMemLow,  refQLow,  4'h7, r, e, w, a, d);
    modelAccess(refMemZero, refQZero, 4'h0, r, e, w, a, d);
    #1;
    checkOutput({tag, "/full"}, qFull, refQFull);
    checkOutput({tag, "/low"},  qLow,  refQLow);
    checkOutput({tag, "/zero"}, qZero, refQZero);
  endtask

  initial begin
    logic [3:0] lowExpect [10];
    lowExpect = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

    rstN = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wrData = '0;
    refQFull = '0; refQLow = '0; refQZero = '0;
    for (int i = 0; i < 16; i++) begin
      refMemFull[i] = '0; refMemLow[i] = '0; refMemZero[i] = '0;
    end

    // Initial reset; Q must be 0 right after the edge.
    applyStimulus("initRst", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    checkOutput("initRstConst", qFull, 4'h0);

    // Reset clears a previously written word.
    applyStimulus("wrA3", 1'b1, 1'b1, 1'b1, 4'd3, 4'hA);
    applyStimulus("rdA3", 1'b1, 1'b1, 1'b0, 4'd3, 4'h0);
    checkOutput("rdA3Const", qFull, 4'hA);
    applyStimulus("rstClr", 1'b0, 1'b1, 1'b0, 4'd3, 4'h0);
    applyStimulus("rdA3Rst", 1'b1, 1'b1, 1'b0, 4'd3, 4'h0);
    checkOutput("rdA3RstConst", qFull, 4'h0);

    // Full-mask write/readback of every address.
    for (int i = 0; i < 16; i++)
      applyStimulus("fillWr", 1'b1, 1'b1, 1'b1, 4'(i), 4'(i) ^ 4'h5);
    for (int i = 0; i < 16; i++) begin
      applyStimulus("fillRd", 1'b1, 1'b1, 1'b0, 4'(i), 4'h0);
      checkOutput("fillRdConst", qFull, 4'(i) ^ 4'h5);
    end

    // Masked writes wrapping round the address space.
    for (int i = 0; i < 10; i++)
      applyStimulus("maskWr", 1'b1, 1'b1, 1'b1, 4'(11 + i), 4'(3 + i));
    for (int i = 0; i < 10; i++) begin
      applyStimulus("maskRd", 1'b1, 1'b1, 1'b0, 4'(11 + i), 4'h0);
      checkOutput("maskRdConst", qLow, lowExpect[i]);
    end

    // Read-first on a write to the same address.
    applyStimulus("preload", 1'b1, 1'b1, 1'b1, 4'd5, 4'd2);
    applyStimulus("rfWr", 1'b1, 1'b1, 1'b1, 4'd5, 4'd9);
    checkOutput("rfOld", qFull, 4'd2);
    applyStimulus("rfRd", 1'b1, 1'b1, 1'b0, 4'd5, 4'h0);
    checkOutput("rfNew", qFull, 4'd9);

    // Enable gating: disabled writes and reads leave memory and Q alone,
    // and Q never follows A between edges.
    for (int i = 0; i < 3; i++)
      applyStimulus("enOffWr", 1'b1, 1'b0, 1'b1, 4'd5, 4'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("enOffRd", 1'b1, 1'b0, 1'b0, 4'(i * 3), 4'h0);
      @(negedge clk);
      addr = 4'(i * 5 + 1);
      #1;
      checkOutput("combA", qFull, 4'd9);
    end
    applyStimulus("enOffChk", 1'b1, 1'b1, 1'b0, 4'd5, 4'h0);
    checkOutput("enOffMem", qFull, 4'd9);

    // Reset pulse between edges has no effect.
    @(negedge clk);
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
    #1;
    checkOutput("midRst", qFull, 4'd9);
    applyStimulus("midRstRd", 1'b1, 1'b1, 1'b0, 4'd5, 4'h0);

    // Reset overrides a simultaneous write.
    applyStimulus("rstVsWr", 1'b0, 1'b1, 1'b1, 4'd6, 4'hF);
    applyStimulus("rstVsWrRd", 1'b1, 1'b1, 1'b0, 4'd6, 4'h0);
    checkOutput("rstVsWrConst", qFull, 4'h0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      applyStimulus("rand", ($urandom_range(0, 39) != 0), 1'($urandom),
                    1'($urandom), 4'($urandom), 4'($urandom));

    // Final sweep of every address in all three instances.
    for (int i = 0; i < 16; i++)
      applyStimulus("sweep", 1'b1, 1'b1, 1'b0, 4'(i), 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_4x4_sp.md
# ram_4x4_sp

Single-port synchronous RAM, 16 words × 4 bits by default, with a registered read port and a per-bit write mask fixed at elaboration. It is a small local storage primitive for control and datapath blocks that need a few bytes of scratch state. It has a synchronous clear and no handshake: every enabled clock edge performs exactly one access.

## Interface
Parameters:
- AW, default 4: address width; depth = 2^AW words.
- DW, default 4: data word width.
- MASK, default {DW{1'b1}} (4'hF): write-enable bit mask. A bit set to 1 is writable; a bit set to 0 is never modified by writes. Overridable per instance.

Ports:
- CLK, input, 1: single clock; all state updates on its rising edge.
- RSTN, input, 1: reset, synchronous, active-low.
- A, input, AW: word address for both read and write.
- D, input, DW: write data.
- EN, input, 1: access enable; when low, no read or write occurs.
- WR, input, 1: 1 = write, 0 = read; only meaningful when EN = 1.
- Q, output, DW: registered read data.

## Operation
- Storage: array mem[0 .. 2^AW-1] of DW bits.
- Priority at each rising CLK edge:
  - RSTN = 0: every mem word is cleared to 0 and Q is cleared to 0. EN, WR, A and D are ignored.
  - Else EN = 0: mem and Q hold their values.
  - Else EN = 1, WR = 1: mem[A] <= (mem[A] & ~MASK) | (D & MASK). Q <= mem[A] value before this write (read-first).
  - Else EN = 1, WR = 0: Q <= mem[A]; mem is unchanged.
- Address: all 2^AW addresses are valid. There is no out-of-range case, and callers truncate wider counters to AW bits.
- MASK = 0: the RAM is effectively read-only and holds zeros after reset.
- MASK is a constant, not a port. Masked bits keep their post-reset value of 0 unless changed by a future design revision.
- No X propagation from uninitialised memory: reset defines every word. Before the first reset, memory content is unspecified.

## Timing
- Read latency is 1 cycle. With A presented before edge N (EN = 1, WR = 0), the data is valid on Q after edge N and holds until the next enabled edge.
- Write takes effect at edge N. A read of the same address at edge N+1 returns the new masked value on Q after N+1.
- Read-during-write to the same address returns old data on Q (read-first). There is no bypass.
- Q changes only on an enabled edge or a reset edge. It never changes combinationally with A.
- Reset mid-operation: an asserted RSTN overrides a simultaneous write. That write is lost, and memory and Q are 0 after the edge.
- Reset is synchronous only. Asserting RSTN between edges has no effect until the next rising edge.

## Test plan
- Reset clear: write 4'hA at A = 3 (MASK = F), assert RSTN = 0 for one edge, then read A = 3 -> Q = 0. Q is also 0 immediately after the reset edge.
- Full-mask write/readback: write D = A ^ 4'h5 at addresses 0..15, then read 0..15 -> Q = A ^ 5 with 1-cycle latency, e.g. A = 2 -> 7 and A = 15 -> 10.
- Masked write (MASK = 7): write D = 3, 4, 5, 6, 7, 8, 9, 10, 11, 12 to A = 11, 12, 13, 14, 15, 0, 1, 2, 3, 4 (address wraps mod 16). Then read A = 11..15, 0..4 -> Q = 3, 4, 5, 6, 7, 0, 1, 2, 3, 4 (bit 3 always 0).
- Read-first: preload A = 5 with 2, then write D = 9 at A = 5 (MASK = F) -> Q = 2 after that edge. The next read of A = 5 -> Q = 9.
- Enable gating: with Q = 9, drive EN = 0, WR = 1, D = 0, A = 5 for 3 edges -> Q stays 9 and mem[5] stays 9. Also drive EN = 0, WR = 0 with a changing A -> Q holds.
- Reset vs write: on the same edge drive RSTN = 0 and EN = 1, WR = 1, A = 6, D = F. Then read A = 6 -> Q = 0.
